// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, constants and parity helper (TX and RX).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;
  localparam int BIT_IDX_W  = $clog2(DATA_W);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic calc_parity(input logic [DATA_W-1:0] data,
                                       input logic              par_typ);
    return (par_typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_bit_timer
// Description : Counts clock cycles within one serial bit; strobes bit_done.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_bit_done
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] w_last;

  // A prescale of zero behaves as one cycle per bit.
  assign w_last     = (i_prescale == '0) ? '0 : i_prescale - 1'b1;
  assign o_bit_done = i_enable & (r_edge_cnt == w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
    end else if (i_clear) begin
      r_edge_cnt <= '0;
    end else if (i_enable) begin
      if (r_edge_cnt == w_last) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8 data bits, optional parity, one stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     P_DATA,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_ready,
  output logic                  TX_OUT,
  output logic                  busy
);

  uart_state_e           r_state;
  uart_state_e           w_state_next;
  logic [DATA_W-1:0]     r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [BIT_IDX_W-1:0]  r_bit_idx;
  logic [BIT_IDX_W-1:0]  w_bit_idx_next;
  logic                  r_tx_out;
  logic                  w_line_next;
  logic                  w_handshake;
  logic                  w_bit_done;
  logic                  w_parity;

  assign tx_ready    = (r_state == IDLE) | ((r_state == STOP) & w_bit_done);
  assign w_handshake = data_valid & tx_ready;
  assign busy        = (r_state != IDLE);
  assign TX_OUT      = r_tx_out;
  assign w_parity    = calc_parity(r_data, r_par_typ);

  uart_tx_bit_timer u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_handshake),
    .i_enable   (busy),
    .i_prescale (r_prescale),
    .o_bit_done (w_bit_done)
  );

  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (w_handshake) w_state_next = START;
      end
      START: begin
        if (w_bit_done) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == LAST_BIT) begin
            w_state_next = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_done) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_done) w_state_next = w_handshake ? START : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the pin flop leads with the FSM.
  always_comb begin
    w_line_next = 1'b1;
    case (w_state_next)
      START:   w_line_next = 1'b0;
      DATA:    w_line_next = r_data[w_bit_idx_next];
      PARITY:  w_line_next = w_parity;
      default: w_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_tx_out  <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx_out  <= w_line_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_prescale <= '0;
    end else if (w_handshake) begin
      r_data     <= P_DATA;
      r_par_en   <= PAR_EN;
      r_par_typ  <= PAR_TYP;
      r_prescale <= prescale;
    end
  end

endmodule
`default_nettype wire
